// File: rtl/dsp_group_feeder.sv
// Operand FIFO plus job FSM that feeds one DSP group and closes its cascade accumulation loop.
// Optional build macro DSP_FEEDER_SKIP_ZERO_EN: zero-valued operands are consumed without issuing a start.
module dsp_group_feeder #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ACCUM_WIDTH        = 48,
  parameter int unsigned SPARSE_INDEX_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned LEN_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [LEN_WIDTH-1:0]          job_len,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [DATA_WIDTH-1:0]         op_activation,
  input  logic [DATA_WIDTH-1:0]         op_weight,
  input  logic [SPARSE_INDEX_WIDTH-1:0] op_sparse_index,
  output logic [DATA_WIDTH-1:0]         dsp_activation,
  output logic [DATA_WIDTH-1:0]         dsp_weight,
  output logic [SPARSE_INDEX_WIDTH-1:0] dsp_sparse_index,
  output logic                          dsp_start,
  output logic [ACCUM_WIDTH-1:0]        dsp_cascade_in,
  input  logic [ACCUM_WIDTH-1:0]        dsp_cascade_out,
  input  logic [ACCUM_WIDTH-1:0]        dsp_output_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ACCUM_WIDTH-1:0]        res_data,
  output logic                          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 2 * DATA_WIDTH + SPARSE_INDEX_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, RESULT} state_t;

  state_t                          state_q, state_d;
  logic [EW-1:0]                   mem_q [FIFO_DEPTH];
  logic [AW-1:0]                   wr_ptr_q, rd_ptr_q;
  logic [AW:0]                     count_q;
  logic [LEN_WIDTH-1:0]            rem_q, rem_d;
  logic                            first_q, first_d;
  logic                            first_issue_q;
  logic                            start_q;
  logic [DATA_WIDTH-1:0]           act_q, wgt_q;
  logic [SPARSE_INDEX_WIDTH-1:0]   sidx_q;
  logic [ACCUM_WIDTH-1:0]          res_data_q, res_data_d;

  logic                            push, pop, skip, issue;
  logic [EW-1:0]                   head;
  logic [DATA_WIDTH-1:0]           head_a, head_w;
  logic [SPARSE_INDEX_WIDTH-1:0]   head_s;

  assign op_ready = (count_q != FULL_CNT);
  assign push     = op_valid && op_ready;
  assign head     = mem_q[rd_ptr_q];
  assign head_a   = head[EW-1 -: DATA_WIDTH];
  assign head_w   = head[SPARSE_INDEX_WIDTH +: DATA_WIDTH];
  assign head_s   = head[SPARSE_INDEX_WIDTH-1:0];

`ifdef DSP_FEEDER_SKIP_ZERO_EN
  assign skip = (head_a == '0) || (head_w == '0);
`else
  assign skip = 1'b0;
`endif
  assign issue = pop && !skip;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    first_d    = first_q;
    res_data_d = res_data_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          if (job_len == '0) begin
            res_data_d = '0;
            state_d    = RESULT;
          end else begin
            rem_d   = job_len;
            first_d = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          rem_d = rem_q - 1'b1;
          if (!skip) first_d = 1'b0;
          if (rem_q == LEN_WIDTH'(1)) begin
            // A job whose operands were all skipped never touched the DSP: report zero directly.
            if (first_q && skip) begin
              res_data_d = '0;
              state_d    = RESULT;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (!start_q) begin
          res_data_d = dsp_output_data;
          state_d    = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_activation, op_weight, op_sparse_index};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rem_q         <= '0;
      first_q       <= 1'b0;
      first_issue_q <= 1'b0;
      start_q       <= 1'b0;
      act_q         <= '0;
      wgt_q         <= '0;
      sidx_q        <= '0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      first_q       <= first_d;
      res_data_q    <= res_data_d;
      start_q       <= issue;
      first_issue_q <= issue && first_q;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        act_q    <= head_a;
        wgt_q    <= head_w;
        sidx_q   <= head_s;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The first issue of a job starts a fresh accumulation; later issues chain through cascade_out.
  assign dsp_cascade_in   = first_issue_q ? '0 : dsp_cascade_out;
  assign dsp_activation   = act_q;
  assign dsp_weight       = wgt_q;
  assign dsp_sparse_index = sidx_q;
  assign dsp_start        = start_q;
  assign job_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign res_valid        = (state_q == RESULT);
  assign res_data         = res_data_q;

endmodule

// File: tb/tb_dsp_group_feeder.sv
// Scoreboard bench for dsp_group_feeder with a behavioural DSP group closing the cascade loop.
module tb_dsp_group_feeder;

  localparam int DW = 8;
  localparam int AW = 48;
  localparam int SW = 1;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [LW-1:0] job_len = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_activation = '0;
  logic [DW-1:0] op_weight = '0;
  logic [SW-1:0] op_sparse_index = '0;
  logic [DW-1:0] dsp_activation, dsp_weight;
  logic [SW-1:0] dsp_sparse_index;
  logic          dsp_start;
  logic [AW-1:0] dsp_cascade_in, dsp_cascade_out, dsp_output_data;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [AW-1:0] res_data;
  logic          busy;

  dsp_group_feeder #(
    .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .SPARSE_INDEX_WIDTH(SW), .FIFO_DEPTH(4), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_activation(op_activation), .op_weight(op_weight), .op_sparse_index(op_sparse_index),
    .dsp_activation(dsp_activation), .dsp_weight(dsp_weight), .dsp_sparse_index(dsp_sparse_index),
    .dsp_start(dsp_start), .dsp_cascade_in(dsp_cascade_in), .dsp_cascade_out(dsp_cascade_out),
    .dsp_output_data(dsp_output_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural DSP group: accumulation visible one cycle after a start.
  logic [AW-1:0] acc;
  always @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (dsp_start) acc <= dsp_cascade_in + AW'(dsp_activation) * AW'(dsp_weight);
  end
  assign dsp_cascade_out = acc;
  assign dsp_output_data = acc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int first_start_cyc = 0;
  int last_start_cyc = 0;
  bit rise_en = 1'b1;
  bit rv_prev = 1'b0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] cas_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && dsp_start) begin
      if (start_cnt == 0) first_start_cyc = cyc;
      last_start_cyc = cyc;
      start_cnt++;
      if (cas_q.size() != 0) check("cascade_in", 64'(dsp_cascade_in), 64'(cas_q.pop_front()));
    end
    if (!rst && res_valid && !rv_prev && rise_en)
      check("res_rise_gap", 64'(cyc - last_start_cyc), 64'd2);
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("spurious_res", 64'd1, 64'd0);
      else check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
    end
    rv_prev = res_valid;
  end

  task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] w, input logic [SW-1:0] s);
    bit ok;
    op_valid = 1'b1; op_activation = a; op_weight = w; op_sparse_index = s;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk) ok = op_ready;
      @(posedge clk);
    end
    if (!ok) check("push_timeout", 64'd1, 64'd0);
    #1 op_valid = 1'b0;
  endtask

  task automatic start_job(input logic [LW-1:0] len);
    bit ok;
    job_valid = 1'b1; job_len = len;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk) ok = job_ready;
      @(posedge clk);
    end
    if (!ok) check("job_timeout", 64'd1, 64'd0);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("result_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk) #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_op_ready", 64'(op_ready), 64'd1);
    check("rst_start", 64'(dsp_start), 64'd0);
    check("rst_act_wgt", 64'({dsp_activation, dsp_weight, dsp_sparse_index}), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk) #1;

    // Back-to-back job
    push_op(8'd2, 8'd3, 1'b0);
    push_op(8'd4, 8'd5, 1'b1);
    push_op(8'd1, 8'd7, 1'b0);
    cas_q.push_back(48'd0); cas_q.push_back(48'd6); cas_q.push_back(48'd26);
    exp_q.push_back(48'd33);
    start_cnt = 0;
    start_job(16'd3);
    wait_empty();
    check("b2b_starts", 64'(start_cnt), 64'd3);
    check("b2b_span", 64'(last_start_cyc - first_start_cyc), 64'd2);
    check("b2b_cascade_used", 64'(cas_q.size()), 64'd0);

    // Zero-length job
    rise_en = 1'b0;
    start_cnt = 0;
    exp_q.push_back(48'd0);
    start_job(16'd0);
    check("zero_res_valid", 64'(res_valid), 64'd1);
    wait_empty();
    check("zero_job_ready", 64'(job_ready), 64'd1);
    check("zero_starts", 64'(start_cnt), 64'd0);
    rise_en = 1'b1;

    // FIFO full and prefetch
    for (int i = 0; i < 4; i++) push_op(8'd1, 8'd1, 1'b0);
    @(negedge clk);
    check("full_op_ready", 64'(op_ready), 64'd0);
    check("full_idle", 64'(busy), 64'd0);
    exp_q.push_back(48'd5);
    @(posedge clk) #1;
    fork
      push_op(8'd1, 8'd1, 1'b0);
      start_job(16'd5);
    join
    wait_empty();

    // Bubbles then result backpressure
    res_ready = 1'b0;
    start_cnt = 0;
    exp_q.push_back(48'd8);
    start_job(16'd4);
    for (int i = 0; i < 4; i++) begin
      push_op(8'd1, 8'd2, 1'b0);
      @(posedge clk) #1;
    end
    for (int i = 0; i < 50 && !res_valid; i++) @(posedge clk) #1;
    check("bub_starts", 64'(start_cnt), 64'd4);
    check("bub_span", 64'(last_start_cyc - first_start_cyc), 64'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_data", 64'(res_data), 64'd8);
      check("bp_job_ready", 64'(job_ready), 64'd0);
    end
    @(posedge clk) #1 res_ready = 1'b1;
    wait_empty();

    // Reset mid-job
    for (int i = 0; i < 4; i++) push_op(8'd1, 8'd1, 1'b0);
    start_cnt = 0;
    start_job(16'd5);
    for (int i = 0; i < 50 && start_cnt < 2; i++) @(negedge clk);
    check("mid_starts", 64'(start_cnt), 64'd2);
    #1 rst = 1'b1;
    #2;
    check("mid_job_ready", 64'(job_ready), 64'd1);
    check("mid_op_ready", 64'(op_ready), 64'd1);
    check("mid_start", 64'(dsp_start), 64'd0);
    check("mid_act", 64'(dsp_activation), 64'd0);
    check("mid_res_valid", 64'(res_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_start", 64'(dsp_start), 64'd0);
    check("post_rst_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk) #1;
    push_op(8'd3, 8'd3, 1'b0);
    exp_q.push_back(48'd9);
    start_job(16'd1);
    wait_empty();

`ifdef DSP_FEEDER_SKIP_ZERO_EN
    push_op(8'd0, 8'd5, 1'b0);
    push_op(8'd2, 8'd0, 1'b0);
    push_op(8'd3, 8'd4, 1'b0);
    push_op(8'd1, 8'd1, 1'b0);
    cas_q.push_back(48'd0); cas_q.push_back(48'd12);
    exp_q.push_back(48'd13);
    start_cnt = 0;
    start_job(16'd4);
    wait_empty();
    check("skip_starts", 64'(start_cnt), 64'd2);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_group_feeder.md
Name: dsp_group_feeder

Overview:
- Producer-side driver for one DSP group: buffers a stream of sparse operands, runs a dot-product job of job_len elements and returns the accumulated result on a valid/ready port.
- Drives the DSP group's activation/weight/sparse-index/start inputs.
- Closes the accumulation loop by routing the group's cascade_out back to its cascade_in.
- Sits between the operand scheduler/buffers and a DSP_Group instance.

Parameters:
- DATA_WIDTH, 8, operand width (activation and weight).
- ACCUM_WIDTH, 48, accumulator/result width.
- SPARSE_INDEX_WIDTH, 1, width of the sparse index passed through to the DSP group.
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
- LEN_WIDTH, 16, width of the job length.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset; the DSP group's rst_n is tied to ~rst at integration.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_len  in  LEN_WIDTH  number of operands in the job; sampled on job handshake.
- op_valid  in  1  operand push request.
- op_ready  out  1  high when the FIFO is not full.
- op_activation  in  DATA_WIDTH  activation operand.
- op_weight  in  DATA_WIDTH  weight operand.
- op_sparse_index  in  SPARSE_INDEX_WIDTH  sparse index for this operand.
- dsp_activation  out  DATA_WIDTH  to the DSP group's activation_in; registered.
- dsp_weight  out  DATA_WIDTH  to the DSP group's weight_in; registered.
- dsp_sparse_index  out  SPARSE_INDEX_WIDTH  to the DSP group's sparse_index; registered.
- dsp_start  out  1  to the DSP group's start; registered.
- dsp_cascade_in  out  ACCUM_WIDTH  to the DSP group's cascade_in.
- dsp_cascade_out  in  ACCUM_WIDTH  from the DSP group's cascade_out.
- dsp_output_data  in  ACCUM_WIDTH  from the DSP group's output_data.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  ACCUM_WIDTH  accumulated result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: FIFO flushed, counters cleared, state IDLE.
  - Outputs after reset: job_ready=1, op_ready=1, dsp_start=0, dsp_activation/weight/sparse_index=0, res_valid=0, res_data=0, busy=0.
  - Reset mid-job aborts the job: no res_valid, and no dsp_start in the cycle after reset deasserts.
- FIFO:
  - Push when op_valid && op_ready.
  - Push is accepted in any state, so operands can prefetch before a job starts.
  - When full, op_ready=0; there is no same-cycle bypass of a full FIFO.
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, RUN, WAIT, RESULT.
  - IDLE -> RUN on job handshake: remaining := job_len, first := 1.
  - If job_len==0: IDLE -> RESULT instead, with res_data := 0 and no dsp_start.
  - RUN, each cycle with FIFO non-empty:
    - Pop one entry.
    - Register its fields onto dsp_activation/weight/sparse_index and set dsp_start=1 in the next cycle (the issue cycle).
    - remaining decrements on each pop.
    - FIFO empty in RUN: dsp_start=0 that cycle (bubble); the state is held.
  - RUN -> WAIT when the pop that makes remaining reach 0 occurs.
  - WAIT: wait until the final issue cycle's accumulation is visible on dsp_output_data.
    - Then capture dsp_output_data into res_data and go to RESULT.
    - res_valid rises exactly 2 cycles after the final dsp_start cycle.
  - RESULT: hold res_valid=1 and a stable res_data until res_ready; then go to IDLE with res_valid=0.
- Cascade loop:
  - dsp_cascade_in = 0 during the job's first issue cycle.
  - In all other cycles, dsp_cascade_in = dsp_cascade_out (combinational pass-through).
  - Back-to-back issues are supported because DSP accumulation is visible on cascade_out one cycle after the start cycle.
- Arithmetic: products are unsigned DATA_WIDTH x DATA_WIDTH. The feeder performs no arithmetic itself; overflow handling belongs to the DSP group.
- Operands left in the FIFO beyond job_len stay for the next job.

Optional Feature:
- Macro: DSP_FEEDER_SKIP_ZERO_EN.
- Defined: a popped operand with op_weight==0 or op_activation==0 is consumed and decrements remaining, but no dsp_start is issued.
  - If the first operands of a job are skipped, first stays set until the first real issue.
  - If every operand is skipped, res_data=0 and res_valid rises 1 cycle after the last pop.
- Undefined: every popped operand is issued.

Test Plan:
- Back-to-back job: job_len=3, ops (2,3),(4,5),(1,7) preloaded, behavioural DSP group attached -> dsp_start high 3 consecutive cycles; dsp_cascade_in 0, 6, 26; res_data=33; res_valid rises 2 cycles after the last start.
- Zero-length job: job_len=0 -> no dsp_start; res_valid=1 the next cycle with res_data=0; job_ready=1 again after res_ready.
- FIFO full and prefetch: FIFO_DEPTH=4, push 5 ops (all 1,1) with no job -> op_ready=0 after 4 pushes, 5th held; then job_len=5 -> all 5 consumed, res_data=5.
- Bubbles and backpressure: op_valid toggled every other cycle during job_len=4 with ops (1,2) -> dsp_start gaps, res_data=8. Then res_ready=0 for 10 cycles -> res_valid and res_data stable, job_ready=0.
- Reset mid-job: assert rst after 2 issues of a job_len=5 job -> all outputs return to reset values, FIFO empty, no res_valid; a new job_len=1 op (3,3) then gives res_data=9.
- With DSP_FEEDER_SKIP_ZERO_EN: job_len=4, ops (0,5),(2,0),(3,4),(1,1) -> 2 dsp_start pulses, the first with cascade_in=0; res_data=13.
